// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU command queue
package alu_pkg;

  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] NOT_A = 2'b10;
  localparam logic [1:0] ROR_B = 2'b11;

  localparam int OPND_W = 4;
  localparam int RES_W  = 5;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous show-ahead FIFO with full/empty/count
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - ALU command FIFO, sequencing FSM and response register
// Optional result checker enabled by ALU_CMD_QUEUE_CHECK_EN.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_opcode,
  input  logic [3:0]             cmd_a,
  input  logic [3:0]             cmd_b,
  output logic [1:0]             alu_opcode,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  input  logic [4:0]             alu_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4:0]             rsp_data,
  output logic [1:0]             rsp_opcode,
  output logic [$clog2(DEPTH):0] count,
  output logic                   chk_err
);

  state_t      r_state;
  logic [1:0]  r_alu_opcode;
  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic        r_rsp_valid;
  logic [4:0]  r_rsp_data;
  logic [1:0]  r_rsp_opcode;

  cmd_t        w_wr_cmd;
  cmd_t        w_rd_cmd;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  assign w_wr_cmd  = {cmd_opcode, cmd_a, cmd_b};
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = !w_empty && ((r_state == ST_IDLE) ||
                                  (r_state == ST_RESP && rsp_ready));
  assign cmd_ready = !w_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_wdata (w_wr_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_rd_cmd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_opcode <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_alu_opcode <= w_rd_cmd.opcode;
            r_alu_a      <= w_rd_cmd.a;
            r_alu_b      <= w_rd_cmd.b;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: r_state <= ST_CAPT;
        ST_CAPT: begin
          r_rsp_data   <= alu_c;
          r_rsp_opcode <= r_alu_opcode;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              r_alu_opcode <= w_rd_cmd.opcode;
              r_alu_a      <= w_rd_cmd.a;
              r_alu_b      <= w_rd_cmd.b;
              r_state      <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_opcode = r_rsp_opcode;

`ifdef ALU_CMD_QUEUE_CHECK_EN
  function automatic logic [RES_W-1:0] golden(input logic [1:0] op,
                                              input logic [OPND_W-1:0] a,
                                              input logic [OPND_W-1:0] b);
    case (op)
      ADD:     return {a[3], a} + {b[3], b};
      SUB:     return {a[3], a} - {b[3], b};
      NOT_A:   return ~{a[3], a};
      default: return {4'b0, |b};
    endcase
  endfunction

  logic r_chk_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk_err <= 1'b0;
    end else if (r_state == ST_CAPT &&
                 alu_c != golden(r_alu_opcode, r_alu_a, r_alu_b)) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - self-checking bench for alu_cmd_queue
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_opcode = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_c = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_data;
  logic [1:0] rsp_opcode;
  logic [$clog2(DEPTH):0] count;
  logic       chk_err;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic force_bad = 1'b0;
  logic [6:0] exp_q[$];
  int hs_q[$];
  logic       hold_valid = 1'b0;
  logic [6:0] hold_val = '0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[8];

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_opcode(rsp_opcode),
    .count(count), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] tb_alu(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic signed [4:0] sa, sb;
    sa = {a[3], a};
    sb = {b[3], b};
    case (op)
      2'b00:   return sa + sb;
      2'b01:   return sa - sb;
      2'b10:   return ~sa;
      default: return (b != 4'd0) ? 5'd1 : 5'd0;
    endcase
  endfunction

  // Registered ALU model feeding alu_c
  always @(posedge clk) begin
    cyc <= cyc + 1;
    alu_c <= force_bad ? 5'd3 : tb_alu(alu_opcode, alu_a, alu_b);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (hold_valid) chk("rsp_hold_stable", {rsp_opcode, rsp_data}, hold_val);
      if (rsp_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          logic [6:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[4:0]);
          chk("rsp_opcode", rsp_opcode, e[6:5]);
        end
      end
    end
    hold_valid = reset && rsp_valid && !rsp_ready;
    hold_val   = {rsp_opcode, rsp_data};
  end

  // Called at posedge+1; returns at accept edge+1.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [4:0] exp);
    int waited = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    else exp_q.push_back({op, exp});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_rsp_valid(input int max);
    int n = 0;
    while (!rsp_valid && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{ADD,   4'd7, 4'd1, 5'b01000};
    vecs[1] = '{SUB,   4'h8, 4'd7, 5'b10001};
    vecs[2] = '{NOT_A, 4'd5, 4'd3, 5'b11010};
    vecs[3] = '{ROR_B, 4'hF, 4'd0, 5'b00000};
    vecs[4] = '{ADD,   4'h8, 4'h8, 5'b10000};
    vecs[5] = '{SUB,   4'd7, 4'h8, 5'b01111};
    vecs[6] = '{NOT_A, 4'hF, 4'd0, 5'b00000};
    vecs[7] = '{ROR_B, 4'd0, 4'h8, 5'b00001};

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_opcode", rsp_opcode, 0);
    chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    chk("rst_count", count, 0);
    chk("rst_chk_err", chk_err, 0);

    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      if (i == 0) begin
        int lat = 0;
        while (!rsp_valid && lat < 10) begin
          @(posedge clk); #1;
          lat++;
        end
        chk("latency", lat, 3);
      end
      wait_drain(50);
    end

    hs_q.delete();
    for (int i = 0; i < 3; i++) push_cmd(ADD, 4'(i), 4'd2, 5'(i + 2));
    wait_drain(60);
    if (hs_q.size() == 3) begin
      chk("throughput_1", hs_q[1] - hs_q[0], 3);
      chk("throughput_2", hs_q[2] - hs_q[1], 3);
    end else begin
      chk("throughput_count", hs_q.size(), 3);
    end

    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [1:0] op;
      logic [3:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      push_cmd(op, a, b, tb_alu(op, a, b));
    end
    chk("full_count", count, DEPTH);
    chk("full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = 4'd1; cmd_b = 4'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("full_blocked_ready", cmd_ready, 0);
    chk("full_blocked_count", count, DEPTH);
    cmd_valid = 1'b0;
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_first_rsp", {rsp_opcode, rsp_data}, exp_q[0]);
    rsp_ready = 1'b1;
    wait_drain(100);
    chk("drained_count", count, 0);
    chk("drained_ready", cmd_ready, 1);

    rsp_ready = 1'b0;
    push_cmd(ADD, 4'd1, 4'd2, 5'd3);
    push_cmd(SUB, 4'd6, 4'd2, 5'd4);
    push_cmd(NOT_A, 4'd3, 4'd1, 5'b11100);
    push_cmd(ROR_B, 4'd1, 4'd1, 5'd1);
    wait_rsp_valid(20);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("pre_rst_count", count, 2);
    chk("pre_rst_alu", {alu_opcode, alu_a, alu_b}, {SUB, 4'd6, 4'd2});
    reset = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_count", count, 0);

`ifdef ALU_CMD_QUEUE_CHECK_EN
    chk("chk_err_clear", chk_err, 0);
    force_bad = 1'b1;
    push_cmd(ADD, 4'd1, 4'd1, 5'd3);
    wait_drain(50);
    force_bad = 1'b0;
    chk("chk_err_set", chk_err, 1);
    push_cmd(ADD, 4'd2, 4'd2, 5'd4);
    wait_drain(50);
    chk("chk_err_sticky", chk_err, 1);
    reset = 1'b0;
    #1;
    chk("chk_err_reset", chk_err, 0);
    @(posedge clk); #1 reset = 1'b1;
`else
    push_cmd(ADD, 4'd1, 4'd1, 5'd2);
    wait_drain(50);
    chk("chk_err_tied", chk_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
